// File: rtl/awgn_pkg.sv
// Shared fixed-point constants and FSM state type for the Box-Muller AWGN datapath.
package awgn_pkg;

    localparam int LOG_W    = 31;
    localparam int LOG_FRAC = 24;
    localparam int F_W      = 17;
    localparam int F_FRAC   = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_e;

endpackage

// File: rtl/sqrt_f_step.sv
// One digit of a non-restoring square root: folds in two radicand bits and
// decides one root bit. Remainder is signed, QW+2 bits wide.
module sqrt_f_step #(
    parameter int QW = 17
) (
    input  logic [QW+1:0] rem_i,
    input  logic [QW-1:0] root_i,
    input  logic [1:0]    bits_i,
    output logic [QW+1:0] rem_o,
    output logic          root_bit_o
);

    logic [QW+1:0] shifted_s;

    // Negative remainder adds back (4q+3), otherwise trial-subtracts (4q+1).
    always_comb begin
        shifted_s = {rem_i[QW-1:0], bits_i};
        if (rem_i[QW+1]) begin
            rem_o = shifted_s + {root_i, 2'b11};
        end else begin
            rem_o = shifted_s - {root_i, 2'b01};
        end
        root_bit_o = ~rem_o[QW+1];
    end

endmodule

// File: rtl/sqrt_f.sv
// f = sqrt(-2*e) with e = ln(u0) in Q7.24, f in Q4.13, one root bit per clock.
// Optional macro SQRT_F_ROUND_EN: one extra guard iteration, round half up, saturate.
module sqrt_f
    import awgn_pkg::*;
#(
    parameter int IN_W     = LOG_W,
    parameter int IN_FRAC  = LOG_FRAC,
    parameter int OUT_W    = F_W,
    parameter int OUT_FRAC = F_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  e_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] f_out,
    output logic             clamp
);

`ifdef SQRT_F_ROUND_EN
    localparam int ITER = OUT_W + 1;
`else
    localparam int ITER = OUT_W;
`endif
    localparam int RADW = 2 * ITER;
    // -2*e scaled from IN_FRAC to 2*ITER-2*OUT_W+2*OUT_FRAC fractional bits
    localparam int SH   = 2 * OUT_FRAC - IN_FRAC + 1 + 2 * (ITER - OUT_W);
    localparam int CW   = $clog2(ITER + 1);

    sqrt_state_e      state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] f_out_q, f_out_d;
    logic             clamp_q, clamp_d;
    logic [RADW-1:0]  rad_q, rad_d;
    logic [ITER+1:0]  rem_q, rem_d;
    logic [ITER-1:0]  root_q, root_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [IN_W-1:0]  mag_s;
    logic [RADW-1:0]  rad_init_s;
    logic             e_pos_s;
    logic [ITER+1:0]  rem_s;
    logic             root_bit_s;
    logic [ITER-1:0]  root_next_s;
    logic [OUT_W-1:0] res_s;
`ifdef SQRT_F_ROUND_EN
    logic [ITER:0]    rnd_s;
`endif

    sqrt_f_step #(.QW(ITER)) u_step (
        .rem_i      (rem_q),
        .root_i     (root_q),
        .bits_i     (rad_q[RADW-1 -: 2]),
        .rem_o      (rem_s),
        .root_bit_o (root_bit_s)
    );

    // Operand preparation and final result formatting.
    always_comb begin
        mag_s       = '0 - e_in;
        rad_init_s  = RADW'(mag_s) << SH;
        e_pos_s     = ~e_in[IN_W-1] & (|e_in[IN_W-2:0]);
        root_next_s = {root_q[ITER-2:0], root_bit_s};
`ifdef SQRT_F_ROUND_EN
        rnd_s = {1'b0, root_next_s} + {{ITER{1'b0}}, 1'b1};
        if (rnd_s[ITER]) begin
            res_s = '1;
        end else begin
            res_s = rnd_s[ITER-1:1];
        end
`else
        res_s = root_next_s;
`endif
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        f_out_d     = f_out_q;
        clamp_d     = clamp_q;
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = CALC;
                    in_ready_d = 1'b0;
                    clamp_d    = e_pos_s;
                    rad_d      = e_pos_s ? '0 : rad_init_s;
                    rem_d      = '0;
                    root_d     = '0;
                    cnt_d      = CW'(ITER);
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rad_d  = rad_q << 2;
                rem_d  = rem_s;
                root_d = root_next_s;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    f_out_d     = res_s;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            f_out_q     <= '0;
            clamp_q     <= 1'b0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            f_out_q     <= f_out_d;
            clamp_q     <= clamp_d;
            rad_q       <= rad_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f_out     = f_out_q;
    assign clamp     = clamp_q;

endmodule

// File: tb/tb_sqrt_f.sv
// Self-checking bench for sqrt_f: directed plan cases plus random inputs
// against an integer-square-root reference model.
module tb_sqrt_f;

    localparam int IN_W     = 31;
    localparam int IN_FRAC  = 24;
    localparam int OUT_W    = 17;
    localparam int OUT_FRAC = 13;
`ifdef SQRT_F_ROUND_EN
    localparam int     LAT     = 18;
    localparam longint EXP_1P5 = 14189;
`else
    localparam int     LAT     = 17;
    localparam longint EXP_1P5 = 14188;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [IN_W-1:0]  e_in = '0;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] f_out;
    logic             clamp;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sqrt_f dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e_in      (e_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_out     (f_out),
        .clamp     (clamp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic longint isqrt(input longint r);
        longint x;
        x = longint'($sqrt(real'(r)));
        while (x * x > r) x--;
        while ((x + 1) * (x + 1) <= r) x++;
        return x;
    endfunction

    // Reference: floor (or half-up rounded, saturated) sqrt of -2e in output scaling.
    function automatic longint model_f(input int e);
        longint r;
        longint x;
        if (e > 0) return 0;
        r = -2 * longint'(e) * (longint'(1) << (2 * OUT_FRAC - IN_FRAC));
`ifdef SQRT_F_ROUND_EN
        x = (isqrt(4 * r) + 1) / 2;
        if (x > (longint'(1) << OUT_W) - 1) x = (longint'(1) << OUT_W) - 1;
`else
        x = isqrt(r);
`endif
        return x;
    endfunction

    task automatic send(input int e);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_send", in_ready, 1);
        in_valid = 1'b1;
        e_in     = IN_W'(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_take", out_valid, 0);
        check("in_ready_after_take", in_ready, 1);
    endtask

    task automatic run(input string tag, input int e, output logic [63:0] f);
        int lat;
        send(e);
        wait_out(lat);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_f"}, f_out, model_f(e));
        check({tag, "_clamp"}, clamp, (e > 0) ? 1 : 0);
        f = f_out;
        take();
    endtask

    initial begin
        logic [63:0] f;
        logic [OUT_W-1:0] held;
        int lat;
        int e;

        #2 rst = 1'b1;
        #10;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_f_out", f_out, 0);
        check("rst_clamp", clamp, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run("neg_half", -8388608, f);
        check("neg_half_const", f, 8192);
        run("neg_one", -16777216, f);
        check("neg_one_const", f, 11585);
        run("neg_32", -536870912, f);
        check("neg_32_const", f, 65536);
        run("zero", 0, f);
        check("zero_const", f, 0);
        run("pos_1000", 1000, f);
        check("pos_1000_const", f, 0);
        run("neg_1p5", -25165824, f);
        check("neg_1p5_const", f, EXP_1P5);
        run("most_neg", -(1 << 30), f);

        // Back-pressure: result held, extra input pulses ignored.
        send(-16777216);
        wait_out(lat);
        check("bp_latency", lat, LAT);
        held = f_out;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            e_in     = IN_W'(-1234567);
            @(posedge clk); #1;
            check("bp_f_stable", f_out, held);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid_high", out_valid, 1);
        end
        in_valid = 1'b0;
        check("bp_f_value", held, model_f(-16777216));
        take();
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_ghost_result", out_valid, 0);

        // Random inputs, mostly non-positive.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 7) == 0) e = int'($urandom_range(1, 32'h3FFF_FFFF));
            else e = -int'($urandom_range(0, 32'h4000_0000));
            run($sformatf("rand%0d", i), e, f);
        end

        // Abort mid-calculation with asynchronous reset.
        send(-8388608);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_f_out", f_out, 0);
        check("abort_clamp", clamp, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run("after_abort", -8388608, f);
        check("after_abort_const", f, 8192);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
